// File: rtl/umem_port_arbiter_pkg.sv
// Shared types for the umem port arbiter: FSM states, access sizes, port owners
// and the rule that decides which data accesses cannot be issued.
package simprisc_umem_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} arb_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} mem_size_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  function automatic logic misaligned(mem_size_e size, logic [1:0] a);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/umem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and umem bus around the arbiter.
// The arbiter takes the slave modport; the core/memory side takes master.
interface umem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/umem_port_arbiter_lane_align.sv
// Byte-lane steering for umem: byte enables and replicated store data on the
// way out, right-justified (unextended) load data on the way back.
module umem_lane_align
  import simprisc_umem_pkg::*;
#(
  parameter int DW = 32
) (
  input  mem_size_e     size,
  input  logic [1:0]    a,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata_raw,
  output logic [3:0]    be,
  output logic [DW-1:0] wdata_rep,
  output logic [DW-1:0] rdata_al
);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << a;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be        = 4'b0011 << a;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rdata_al = rdata_raw >> {a, 3'b000};

endmodule

// File: rtl/umem_port_arbiter.sv
// Shares single-port umem between instruction fetch and load/store, one access
// at a time. Define UMEM_STARVE_GUARD_EN to force a fetch after STARVE_LIMIT data grants.
module umem_port_arbiter
  import simprisc_umem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  umem_port_arbiter_if.slave bus
);

  arb_state_e    state, state_nx;
  logic [2:0]    lat_cnt, lat_cnt_nx;
  owner_e        own_q;
  logic          we_q;
  mem_size_e     size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic          live, issue, done, starved, d_bad, pick_if, pick_d;
  logic [3:0]    be;
  logic [DW-1:0] wdata_rep, rdata_al;

`ifdef UMEM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  // Only data grants that actually kept a waiting fetch out advance the count.
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (pick_if)
      starve_cnt <= '0;
    else if (pick_d)
      starve_cnt <= !bus.if_req ? '0 : (starved ? starve_cnt : starve_cnt + 1'b1);
  end
`else
  assign starved = 1'b0;
`endif

  assign live    = !reset;
  assign issue   = live && (state == ISSUE);
  assign done    = live && (state == DONE);
  assign d_bad   = misaligned(mem_size_e'(bus.d_size), bus.d_addr[1:0]);
  assign pick_if = live && (state == IDLE) && bus.if_req && (!bus.d_req || starved);
  assign pick_d  = live && (state == IDLE) && bus.d_req && !pick_if;

  umem_lane_align #(.DW(DW)) u_align (
    .size      (size_q),
    .a         (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata_raw (bus.mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_al  (rdata_al)
  );

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    case (state)
      IDLE: begin
        if (pick_d)
          state_nx = d_bad ? ERR : ISSUE;
        else if (pick_if)
          state_nx = ISSUE;
      end
      ISSUE: begin
        if (we_q || MEM_LAT == 1) begin
          state_nx = DONE;
        end else begin
          lat_cnt_nx = 3'(MEM_LAT - 1);
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_nx = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Fetches are recorded as word-aligned word reads so the lane logic needs no owner input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      own_q      <= OWN_IF;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      if (pick_d) begin
        own_q   <= OWN_D;
        we_q    <= bus.d_we;
        size_q  <= mem_size_e'(bus.d_size);
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
      end else if (pick_if) begin
        own_q   <= OWN_IF;
        we_q    <= 1'b0;
        size_q  <= SZ_W;
        addr_q  <= {bus.if_addr[AW-1:2], 2'b00};
        wdata_q <= '0;
      end
      if (state == DONE) begin
        if (own_q == OWN_IF)
          if_rdata_q <= rdata_al;
        else
          d_rdata_q <= we_q ? '0 : rdata_al;
      end
      if (state == ERR)
        d_rdata_q <= '0;
    end
  end

  assign bus.if_gnt    = pick_if;
  assign bus.d_gnt     = pick_d;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && we_q;
  assign bus.mem_be    = issue ? be : 4'b0000;
  assign bus.mem_addr  = issue ? {addr_q[AW-1:2], 2'b00} : '0;
  assign bus.mem_wdata = issue ? wdata_rep : '0;

  assign bus.if_rvalid = done && (own_q == OWN_IF);
  assign bus.d_rvalid  = (done && (own_q == OWN_D)) || (live && state == ERR);
  assign bus.d_err     = live && (state == ERR);
  assign bus.if_rdata  = (done && own_q == OWN_IF) ? rdata_al : if_rdata_q;
  assign bus.d_rdata   = (done && own_q == OWN_D) ? (we_q ? '0 : rdata_al) : d_rdata_q;

endmodule

// File: tb/tb_umem_port_arbiter.sv
// Scoreboard bench for umem_port_arbiter: one instance at MEM_LAT=1 with a byte-lane
// memory model, one at MEM_LAT=3 for latency and mid-access reset.
module tb_umem_port_arbiter;

   localparam int LAT1 = 1;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_maddr;
      logic [3:0]  exp_be;
      logic [31:0] exp_mwdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } req_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        chk_rdata;
      logic        err;
      int          cyc;
   } rv_exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   mem_exp_t exp_mem[$];
   rv_exp_t  exp_d[$];
   rv_exp_t  exp_if[$];
   logic     grant_log[$];
   int       grant_cyc[$];

   logic [31:0] mem1 [0:255];
   logic [31:0] pipe1;
   logic [31:0] p3 [0:2];
   int          rv3_cnt = 0, rv3_cyc = 0, m3_cnt = 0;
   logic [31:0] rv3_data = '0, m3_addr = '0;
   logic [3:0]  m3_be = '0;

   umem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
   umem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

   umem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1), .STARVE_LIMIT(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   umem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   always #5 clk = ~clk;

   // Free-running cycle number used to time-stamp grants and responses.
   always @(posedge clk) cyc <= cyc + 1;

   // Byte-lane umem for the MEM_LAT=1 instance; reads show up one cycle after mem_en.
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem1[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      pipe1 <= (bus.mem_en && !bus.mem_we) ? mem1[bus.mem_addr[9:2]] : 32'hBAD0BAD0;
   end
   assign bus.mem_rdata = pipe1;

   // Three-deep read pipe for the MEM_LAT=3 instance with a fixed memory word.
   always @(posedge clk) begin
      p3[0] <= bus3.mem_en ? 32'h1234ABCD : 32'hBAD0BAD0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bus3.mem_rdata = p3[2];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic req_t mk_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] maddr, input logic [3:0] be,
                                   input logic [31:0] mwdata, input logic [31:0] rdata, input logic err);
      req_t r;
      r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
      r.exp_maddr = maddr; r.exp_be = be; r.exp_mwdata = mwdata;
      r.exp_rdata = rdata; r.exp_err = err;
      return r;
   endfunction

   task automatic push_exp(input req_t r, input bit is_d, input int gcyc);
      mem_exp_t m;
      rv_exp_t  e;
      if (!r.exp_err) begin
         m.addr = r.exp_maddr; m.be = r.exp_be; m.we = r.we; m.wdata = r.exp_mwdata;
         exp_mem.push_back(m);
      end
      e.rdata = r.exp_rdata;
      e.chk_rdata = !r.exp_err;
      e.err = r.exp_err;
      e.cyc = gcyc + (r.exp_err ? 1 : (r.we ? 2 : LAT1 + 1));
      if (is_d) exp_d.push_back(e);
      else exp_if.push_back(e);
   endtask

   // Pops the scoreboard whenever the MEM_LAT=1 instance touches memory or responds.
   always @(negedge clk) begin : monitor1
      mem_exp_t m;
      rv_exp_t  e;
      if (bus.mem_en) begin
         if (exp_mem.size() == 0) checkOutput("mem_en_unexpected", 32'(bus.mem_en), 32'd0);
         else begin
            m = exp_mem.pop_front();
            checkOutput("mem_addr", bus.mem_addr, m.addr);
            checkOutput("mem_be", 32'(bus.mem_be), 32'(m.be));
            checkOutput("mem_we", 32'(bus.mem_we), 32'(m.we));
            if (m.we) checkOutput("mem_wdata", bus.mem_wdata, m.wdata);
         end
      end
      if (bus.d_rvalid) begin
         if (exp_d.size() == 0) checkOutput("d_rvalid_unexpected", 32'(bus.d_rvalid), 32'd0);
         else begin
            e = exp_d.pop_front();
            checkOutput("d_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("d_err", 32'(bus.d_err), 32'(e.err));
            if (e.chk_rdata) checkOutput("d_rdata", bus.d_rdata, e.rdata);
         end
      end else if (bus.d_err) checkOutput("d_err_without_rvalid", 32'(bus.d_err), 32'd0);
      if (bus.if_rvalid) begin
         if (exp_if.size() == 0) checkOutput("if_rvalid_unexpected", 32'(bus.if_rvalid), 32'd0);
         else begin
            e = exp_if.pop_front();
            checkOutput("if_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("if_rdata", bus.if_rdata, e.rdata);
         end
      end
   end

   always @(negedge clk) begin : monitor3
      if (bus3.mem_en) begin
         m3_cnt++;
         m3_be = bus3.mem_be;
         m3_addr = bus3.mem_addr;
      end
      if (bus3.d_rvalid) begin
         rv3_cnt++;
         rv3_cyc = cyc;
         rv3_data = bus3.d_rdata;
      end
   end

   // Raises the selected requests, logs grants in order, and drops each request after its grant.
   task automatic applyStimulus(input req_t dr, input bit use_d, input req_t ir, input bit use_i);
      bit pend_d, pend_i;
      grant_log.delete();
      grant_cyc.delete();
      @(posedge clk); #1;
      pend_d = use_d;
      pend_i = use_i;
      if (use_d) begin
         bus.d_req = 1'b1; bus.d_we = dr.we; bus.d_size = dr.size;
         bus.d_addr = dr.addr; bus.d_wdata = dr.wdata;
      end
      if (use_i) begin
         bus.if_req = 1'b1; bus.if_addr = ir.addr;
      end
      for (int n = 0; n < 20 && (pend_d || pend_i); n++) begin
         @(negedge clk);
         if (pend_d && bus.d_gnt) begin
            push_exp(dr, 1'b1, cyc); grant_log.push_back(1'b1); grant_cyc.push_back(cyc); pend_d = 1'b0;
         end
         if (pend_i && bus.if_gnt) begin
            push_exp(ir, 1'b0, cyc); grant_log.push_back(1'b0); grant_cyc.push_back(cyc); pend_i = 1'b0;
         end
         @(posedge clk); #1;
         if (!pend_d) bus.d_req = 1'b0;
         if (!pend_i) bus.if_req = 1'b0;
      end
      checkOutput("gnt_timeout", {30'b0, pend_d, pend_i}, 32'd0);
      bus.d_req = 1'b0;
      bus.if_req = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 20; n++) begin
         if (exp_mem.size() == 0 && exp_d.size() == 0 && exp_if.size() == 0) break;
         @(negedge clk);
      end
      checkOutput("drain", 32'(exp_mem.size() + exp_d.size() + exp_if.size()), 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      req_t none, ld, fe;
      int   g3, g4, rv_before;
      bit   exp_fetch;
      for (int i = 0; i < 256; i++) mem1[i] = 32'h0;
      mem1[32'h10 >> 2] = 32'hDEADBEEF;
      mem1[32'h20 >> 2] = 32'hCAFEF00D;
      mem1[32'h40 >> 2] = 32'h01234567;
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
      bus3.if_req = 0; bus3.if_addr = 0; bus3.d_req = 0; bus3.d_we = 0; bus3.d_size = 0; bus3.d_addr = 0; bus3.d_wdata = 0;
      none = '0;

      // Reset: even with both requests up, nothing is granted and every output is zero.
      repeat (2) @(posedge clk);
      #1; bus.if_req = 1'b1; bus.d_req = 1'b1;
      @(negedge clk);
      checkOutput("rst_ctrl", 32'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.d_err,
                                   bus.mem_en, bus.mem_we, bus.mem_be}), 32'd0);
      checkOutput("rst_data", bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.d_rdata, 32'd0);
      @(posedge clk); #1;
      bus.if_req = 1'b0; bus.d_req = 1'b0; reset = 1'b0;

      // Fetch from an unaligned address is issued as a word read of the enclosing word.
      fe = mk_req(1'b0, 2'd2, 32'h13, 32'h0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
      applyStimulus(none, 1'b0, fe, 1'b1);
      drain();
      repeat (3) @(negedge clk);
      checkOutput("if_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

      // Simultaneous requests: data first, fetch granted in the IDLE cycle after DONE.
      ld = mk_req(1'b0, 2'd2, 32'h20, 32'h0, 32'h20, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
      fe = mk_req(1'b0, 2'd2, 32'h40, 32'h0, 32'h40, 4'hF, 32'h0, 32'h01234567, 1'b0);
      applyStimulus(ld, 1'b1, fe, 1'b1);
      drain();
      checkOutput("prio_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         checkOutput("prio_first_is_data", 32'(grant_log[0]), 32'd1);
         checkOutput("prio_fetch_gap", 32'(grant_cyc[1] - grant_cyc[0]), 32'(LAT1 + 2));
      end
      checkOutput("d_rdata_hold", bus.d_rdata, 32'hCAFEF00D);

      // Stores: lane enables and replicated data, then readback through the memory model.
      applyStimulus(mk_req(1'b1, 2'd0, 32'h102, 32'h000000A5, 32'h100, 4'b0100, 32'hA5A5A5A5, 32'h0, 1'b0), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b0, 2'd0, 32'h102, 32'h0, 32'h100, 4'b0100, 32'h0, 32'h000000A5, 1'b0), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b1, 2'd1, 32'h106, 32'h0000BEEF, 32'h104, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b0, 2'd2, 32'h104, 32'h0, 32'h104, 4'hF, 32'h0, 32'hBEEF0000, 1'b0), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b1, 2'd2, 32'h108, 32'h11223344, 32'h108, 4'hF, 32'h11223344, 32'h0, 1'b0), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b0, 2'd1, 32'h10A, 32'h0, 32'h108, 4'b1100, 32'h0, 32'h00001122, 1'b0), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b0, 2'd0, 32'h109, 32'h0, 32'h108, 4'b0010, 32'h0, 32'h00112233, 1'b0), 1'b1, none, 1'b0);
      drain();

      // Misaligned half, misaligned word and illegal size: error response, no memory cycle.
      applyStimulus(mk_req(1'b0, 2'd1, 32'h103, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b1, 2'd2, 32'h106, 32'h55, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1), 1'b1, none, 1'b0);
      drain();
      applyStimulus(mk_req(1'b0, 2'd3, 32'h100, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1), 1'b1, none, 1'b0);
      drain();

      // Both requests held high: fetch is either starved or let through every fifth grant.
      ld = mk_req(1'b0, 2'd2, 32'h20, 32'h0, 32'h20, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
      fe = mk_req(1'b0, 2'd2, 32'h10, 32'h0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
      grant_log.delete();
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h20; bus.d_wdata = 32'h0;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      for (int n = 0; n < 45; n++) begin
         @(negedge clk);
         if (bus.d_gnt) begin push_exp(ld, 1'b1, cyc); grant_log.push_back(1'b1); end
         if (bus.if_gnt) begin push_exp(fe, 1'b0, cyc); grant_log.push_back(1'b0); end
      end
      @(posedge clk); #1;
      bus.d_req = 1'b0; bus.if_req = 1'b0;
      drain();
      checkOutput("starve_grant_count", 32'(grant_log.size() >= 10), 32'd1);
      for (int k = 0; k < grant_log.size(); k++) begin
`ifdef UMEM_STARVE_GUARD_EN
         exp_fetch = (k % 5) == 4;
`else
         exp_fetch = 1'b0;
`endif
         checkOutput($sformatf("starve_grant_%0d_is_data", k), 32'(grant_log[k]), 32'(!exp_fetch));
      end

      // MEM_LAT=3 instance: LHU at byte 2 comes back right-justified four cycles after grant.
      @(posedge clk); #1;
      bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_size = 2'd1; bus3.d_addr = 32'h2;
      g3 = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus3.d_gnt) begin g3 = cyc; break; end
      end
      @(posedge clk); #1;
      bus3.d_req = 1'b0;
      checkOutput("lat3_gnt_timeout", 32'(g3 < 0), 32'd0);
      for (int n = 0; n < 12; n++) begin
         if (rv3_cnt != 0) break;
         @(negedge clk);
      end
      checkOutput("lat3_rvalid_count", 32'(rv3_cnt), 32'd1);
      checkOutput("lat3_rdata", rv3_data, 32'h00001234);
      checkOutput("lat3_latency", 32'(rv3_cyc - g3), 32'd4);
      checkOutput("lat3_mem_be", 32'(m3_be), 32'b1100);
      checkOutput("lat3_mem_addr", m3_addr, 32'h0);

      // Reset while waiting on memory: the access vanishes without a response.
      repeat (2) @(posedge clk);
      #1;
      bus3.d_req = 1'b1;
      g4 = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus3.d_gnt) begin g4 = cyc; break; end
      end
      checkOutput("rst_wait_gnt_timeout", 32'(g4 < 0), 32'd0);
      @(posedge clk); #1;
      bus3.d_req = 1'b0;
      @(posedge clk); #1;
      rv_before = rv3_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_wait_ctrl", 32'({bus3.if_gnt, bus3.if_rvalid, bus3.d_gnt, bus3.d_rvalid, bus3.d_err,
                                        bus3.mem_en, bus3.mem_we, bus3.mem_be}), 32'd0);
      checkOutput("rst_wait_data", bus3.mem_addr | bus3.mem_wdata | bus3.if_rdata | bus3.d_rdata, 32'd0);
      repeat (8) @(negedge clk);
      checkOutput("rst_wait_no_rvalid", 32'(rv3_cnt - rv_before), 32'd0);
      checkOutput("rst_wait_mem_en_count", 32'(m3_cnt), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
